// File: rtl/compare_serial_n.sv
// ---------------------------------------------------------------------------
// compare_serial_n
//
// Sequential magnitude comparator. Two WIDTH-bit operands are captured on a
// start request and compared DIGIT bits per clock, most significant digit
// first. The comparison stops on the first digit that differs, so the result
// arrives after k+1 cycles (k = index of that digit, 0 = most significant).
// Equal operands take NDIG cycles. No full-width carry chain is needed, which
// is the point of this block for wide operands.
//
// Parameters
//   WIDTH  operand width in bits; must be a multiple of DIGIT
//   DIGIT  bits compared per clock; DIGIT == WIDTH gives a one-cycle compare
//
// Ports
//   clk    in   1      single clock, all state on the rising edge
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request; a/b captured on the edge where start=1, busy=0
//   a      in   WIDTH  operand A, sampled only at capture
//   b      in   WIDTH  operand B, sampled only at capture
//   busy   out  1      high while a comparison is in progress
//   done   out  1      one-cycle pulse: lt/gt/eq have just been updated
//   lt     out  1      A <  B, held from done until the next capture
//   gt     out  1      A >  B, held
//   eq     out  1      A == B, held
//
// Configuration macro
//   SIGNED_CMP_EN  when defined, operands are two's complement. The sign bit
//                  of both operands is inverted at capture (offset binary),
//                  which maps signed order onto unsigned order, so the digit
//                  compare itself is unchanged. Latency rules are identical.
//                  When undefined, operands are unsigned.
// ---------------------------------------------------------------------------
module compare_serial_n #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG) + 1;

  // Counter value of the least significant digit; reaching it with equal
  // digits means the whole operands are equal.
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  // Pattern XORed into both operands at capture. Flipping the sign bit turns
  // two's complement into offset binary, whose unsigned order matches the
  // signed order of the original values.
`ifdef SIGNED_CMP_EN
  localparam logic [WIDTH-1:0] CAP_XOR = WIDTH'(1) << (WIDTH - 1);
`else
  localparam logic [WIDTH-1:0] CAP_XOR = '0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;
  logic             dig_gt;
  logic             dig_lt;
  logic             last_dig;

  // The digit under test always sits at the top of the shift registers;
  // equal digits shift the next one up into place.
  always_comb begin
    da       = sa[WIDTH-1 -: DIGIT];
    db       = sb[WIDTH-1 -: DIGIT];
    dig_gt   = (da > db);
    dig_lt   = (da < db);
    last_dig = (cnt == LAST_DIG);
  end

  // Controller and datapath. done defaults low every cycle so it can only
  // ever be a single-cycle pulse. Results are cleared at capture and set
  // exactly once when the comparison resolves, which keeps lt/gt/eq one-hot
  // after done and all-zero while a comparison is pending. start is only
  // looked at in IDLE, so a request while busy has no effect; since the
  // resolving edge already returns to IDLE, a start in the done cycle is
  // accepted and back-to-back comparisons need no idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a ^ CAP_XOR;
            sb    <= b ^ CAP_XOR;
            cnt   <= '0;
            lt    <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (dig_gt) begin
            gt    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (dig_lt) begin
            lt    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (last_dig) begin
            eq    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            sa  <= sa << DIGIT;
            sb  <= sb << DIGIT;
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compare_serial_n.sv
// ---------------------------------------------------------------------------
// tb_compare_serial_n
//
// Bench for compare_serial_n. Two instances share clock and reset: a 16-bit
// comparator with 4-bit digits for the directed scenarios, and a 4-bit
// single-digit comparator for an exhaustive sweep of all operand pairs.
// Stimulus pushes the expected {lt,gt,eq} and the cycle in which done must
// appear into a queue; a monitor pops an entry on every done pulse.
// Expected results follow SIGNED_CMP_EN when the macro is defined.
// ---------------------------------------------------------------------------
module tb_compare_serial_n;

  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  typedef struct {
    logic [2:0] res;
    int         done_cyc;
    string      name;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        lt;
  logic        gt;
  logic        eq;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic        lt4;
  logic        gt4;
  logic        eq4;

  int   cyc;
  int   checks;
  int   errors;
  exp_t sbq[$];
  exp_t sbq4[$];
  exp_t e16;
  exp_t e4;

  compare_serial_n #(.WIDTH(16), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .lt    (lt),
    .gt    (gt),
    .eq    (eq)
  );

  compare_serial_n #(.WIDTH(4), .DIGIT(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .lt    (lt4),
    .gt    (gt4),
    .eq    (eq4)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter stepped on every rising edge; read only on falling edges.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Reference result for the 4-bit sweep.
  function automatic logic [2:0] model4(input logic [3:0] x, input logic [3:0] y);
`ifdef SIGNED_CMP_EN
    if ($signed(x) < $signed(y)) return RES_LT;
    if ($signed(x) > $signed(y)) return RES_GT;
`else
    if (x < y) return RES_LT;
    if (x > y) return RES_GT;
`endif
    return RES_EQ;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation,
  // both in result and in the cycle it appears. A done with nothing queued
  // (extra pulse, pulse after reset abort) is a failure.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_done: got lt/gt/eq=%b at cycle %0d, required no done", {lt, gt, eq}, cyc);
      end else begin
        e16 = sbq.pop_front();
        if ({lt, gt, eq} !== e16.res || cyc != e16.done_cyc) begin
          errors++;
          $display("[TB] FAIL %s: got lt/gt/eq=%b at cycle %0d, required %b at cycle %0d",
                   e16.name, {lt, gt, eq}, cyc, e16.res, e16.done_cyc);
        end
      end
    end
    if (done4) begin
      checks++;
      if (sbq4.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_done4: got lt/gt/eq=%b at cycle %0d, required no done", {lt4, gt4, eq4}, cyc);
      end else begin
        e4 = sbq4.pop_front();
        if ({lt4, gt4, eq4} !== e4.res || cyc != e4.done_cyc) begin
          errors++;
          $display("[TB] FAIL %s: got lt/gt/eq=%b at cycle %0d, required %b at cycle %0d",
                   e4.name, {lt4, gt4, eq4}, cyc, e4.res, e4.done_cyc);
        end
      end
    end
  end

  // Direct comparison of the 16-bit instance's outputs at the current time.
  task automatic checkOutput(input string name, input logic exp_busy,
                             input logic exp_done, input logic [2:0] exp_res);
    checks++;
    if ({busy, done, lt, gt, eq} !== {exp_busy, exp_done, exp_res}) begin
      errors++;
      $display("[TB] FAIL %s: got busy/done/lt/gt/eq=%b, required %b",
               name, {busy, done, lt, gt, eq}, {exp_busy, exp_done, exp_res});
    end
  endtask

  // Wait on a falling edge until the selected instance is idle; bounded.
  task automatic waitIdle(input bit wide);
    int n;
    n = 0;
    while ((wide ? busy : busy4) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (wide ? busy : busy4) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: got busy=1 after %0d cycles, required busy=0", n);
    end
  endtask

  // Issue one single-cycle start and queue the expected result, which must
  // appear lat cycles after the capture edge.
  task automatic applyStimulus(input bit wide, input string name,
                               input logic [15:0] va, input logic [15:0] vb,
                               input logic [2:0] res, input int lat);
    waitIdle(wide);
    @(negedge clk);
    if (wide) begin
      a     = va;
      b     = vb;
      start = 1'b1;
      sbq.push_back('{res: res, done_cyc: cyc + 1 + lat, name: name});
    end else begin
      a4     = va[3:0];
      b4     = vb[3:0];
      start4 = 1'b1;
      sbq4.push_back('{res: res, done_cyc: cyc + 1 + lat, name: name});
    end
    @(negedge clk);
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  initial begin
    int c0;
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b1;
    a      = 16'h1234;
    b      = 16'h0000;
    start4 = 1'b1;
    a4     = 4'h3;
    b4     = 4'h1;

    // Reset held with start high: nothing may be captured.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("reset_idle", 1'b0, 1'b0, RES_NONE);
    end
    start  = 1'b0;
    start4 = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_idle", 1'b0, 1'b0, RES_NONE);

    // Equal operands: full NDIG cycles, eq held afterwards.
    applyStimulus(1'b1, "eq_1234", 16'h1234, 16'h1234, RES_EQ, 4);
    checkOutput("eq_pending", 1'b1, 1'b0, RES_NONE);
    repeat (5) @(negedge clk);
    checkOutput("eq_held", 1'b0, 1'b0, RES_EQ);

    // Early exit on the most significant digit.
`ifdef SIGNED_CMP_EN
    applyStimulus(1'b1, "ms_digit_A000_1FFF", 16'hA000, 16'h1FFF, RES_LT, 1);
`else
    applyStimulus(1'b1, "ms_digit_A000_1FFF", 16'hA000, 16'h1FFF, RES_GT, 1);
`endif

    // First difference in digit 1.
    applyStimulus(1'b1, "digit1_12F0_1300", 16'h12F0, 16'h1300, RES_LT, 2);
    repeat (3) @(negedge clk);
    checkOutput("lt_held", 1'b0, 1'b0, RES_LT);

    // start held for six edges, a changed after capture: first result uses
    // the captured a, then the done-cycle recapture picks up the new a.
    waitIdle(1'b1);
    @(negedge clk);
    a     = 16'h0001;
    b     = 16'h0002;
    start = 1'b1;
    c0    = cyc;
    sbq.push_back('{res: RES_LT, done_cyc: c0 + 1 + 4, name: "held_start_first"});
`ifdef SIGNED_CMP_EN
    sbq.push_back('{res: RES_LT, done_cyc: c0 + 6 + 1, name: "held_start_recapture"});
`else
    sbq.push_back('{res: RES_GT, done_cyc: c0 + 6 + 1, name: "held_start_recapture"});
`endif
    @(negedge clk);
    @(negedge clk);
    a = 16'hFFFF;
    checkOutput("held_start_busy", 1'b1, 1'b0, RES_NONE);
    repeat (4) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during RUN abandons the comparison without a done pulse.
    waitIdle(1'b1);
    @(negedge clk);
    a     = 16'h0000;
    b     = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("abort_captured", 1'b1, 1'b0, RES_NONE);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_async_clear", 1'b0, 1'b0, RES_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("abort_no_done", 1'b0, 1'b0, RES_NONE);
    applyStimulus(1'b1, "after_abort_0000_0001", 16'h0000, 16'h0001, RES_LT, 4);

    // Sign-bit case: result flips with operand interpretation.
`ifdef SIGNED_CMP_EN
    applyStimulus(1'b1, "sign_8000_0001", 16'h8000, 16'h0001, RES_LT, 1);
`else
    applyStimulus(1'b1, "sign_8000_0001", 16'h8000, 16'h0001, RES_GT, 1);
`endif

    // Exhaustive sweep on the single-digit instance.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        applyStimulus(1'b0, "sweep4", 16'(i), 16'(j), model4(4'(i), 4'(j)), 1);
      end
    end

    waitIdle(1'b1);
    waitIdle(1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (sbq.size() != 0 || sbq4.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_done: got %0d/%0d outstanding, required 0/0", sbq.size(), sbq4.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
